cpu_mem_bridge: RTL

Bus bridge between the 6502 core (cpu) and the PSRAM memory controller (memCtrl).
It captures one CPU bus cycle, maps its 16-bit address into the 24-bit PSRAM space and runs the memCtrl chip-select/busy/dataReady handshake. It holds the CPU off via RDY until the access completes, then returns read data.
It replaces the hand-written RAM-test sequencer in gm64 as memCtrl's sole requester.

---
 rtl/gm64_pkg.sv | 29 ++
 rtl/bridge_timer.sv | 37 +++
 rtl/cpu_mem_bridge.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gm64_pkg.sv
// rtl/gm64_pkg.sv - shared types and constants for the gm64 memory path
//
// Purpose : bridge FSM state encoding, PSRAM address width, the data value
//           returned to the CPU on an aborted read, and the CPU-to-PSRAM
//           address mapping helper.
// Ports   : none (package)
package gm64_pkg;

    localparam int PSRAM_ADDR_W = 24;

    localparam logic [7:0] BRIDGE_ABORT_DATA = 8'hFF;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ISSUE       = 3'd1,
        WAIT_ACCEPT = 3'd2,
        WAIT_DONE   = 3'd3,
        COMPLETE    = 3'd4
    } BridgeState;

    // CPU address offset into PSRAM; the sum wraps at 2^24 with no carry out.
    function automatic logic [PSRAM_ADDR_W-1:0] map_cpu_addr(
        input logic [PSRAM_ADDR_W-1:0] base,
        input logic [15:0]             cpu_addr
    );
        return base + {8'h00, cpu_addr};
    endfunction

endpackage

// File: rtl/bridge_timer.sv
// rtl/bridge_timer.sv - clearable up-counter flagging when LIMIT-1 is reached
//
// Purpose : wait-state watchdog. Counts enabled cycles from zero and raises
//           o_expired once the count equals LIMIT-1; the count then holds.
// Ports   : clkSys    - system clock
//           reset     - asynchronous active-low reset
//           i_clear   - load zero (has priority over i_enable)
//           i_enable  - count this cycle
//           o_expired - count has reached LIMIT-1
module bridge_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clkSys,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && !o_expired) begin
            count <= count + 1'b1;
        end
    end

    assign o_expired = (count == LAST);

endmodule

// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - 6502 bus cycle to PSRAM memCtrl request bridge
//
// Purpose : captures one CPU bus cycle, maps the 16-bit address into PSRAM,
//           runs the memCtrl chip-select/busy/dataReady handshake and stalls
//           the CPU through o_cpuRdy until the access completes or times out.
// Ports   : clkSys, reset (async active-low)
//           i_cpuStrobe/i_cpuAddr/i_cpuDataOut/i_cpuWE - CPU bus cycle
//           o_cpuDataIn/o_cpuRdy                        - CPU return path
//           o_memCs/o_memWrite/o_memAddress/o_memBank/o_memDataToWrite
//                                                       - memCtrl request
//           i_memBusy/i_memDataReady/i_memDataRead      - memCtrl status
//           o_timeout/o_overrun                         - sticky error flags
module cpu_mem_bridge
    import gm64_pkg::*;
#(
    parameter logic [PSRAM_ADDR_W-1:0] BASE_ADDR = 24'h000000,
    parameter logic                    BANK      = 1'b1,
    parameter int                      TIMEOUT   = 1024
) (
    input  logic                    clkSys,
    input  logic                    reset,
    input  logic                    i_cpuStrobe,
    input  logic [15:0]             i_cpuAddr,
    input  logic [7:0]              i_cpuDataOut,
    input  logic                    i_cpuWE,
    output logic [7:0]              o_cpuDataIn,
    output logic                    o_cpuRdy,
    output logic                    o_memCs,
    output logic                    o_memWrite,
    output logic [PSRAM_ADDR_W-1:0] o_memAddress,
    output logic                    o_memBank,
    output logic [7:0]              o_memDataToWrite,
    input  logic                    i_memBusy,
    input  logic                    i_memDataReady,
    input  logic [7:0]              i_memDataRead,
    output logic                    o_timeout,
    output logic                    o_overrun
);

    BridgeState state_q;
    BridgeState state_d;

    logic cs_pulse;
    logic capture_read;
    logic abort;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // The timer restarts on every state change so each wait state gets its
    // own TIMEOUT budget; it only runs while an access is outstanding.
    assign timer_clear  = (state_q == IDLE) || (state_q == COMPLETE) || (state_d != state_q);
    assign timer_enable = !timer_clear;

    bridge_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clkSys   (clkSys),
        .reset    (reset),
        .i_clear  (timer_clear),
        .i_enable (timer_enable),
        .o_expired(timer_expired)
    );

    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Progress always wins over expiry when both happen in the same cycle.
    always_comb begin
        state_d      = state_q;
        cs_pulse     = 1'b0;
        capture_read = 1'b0;
        abort        = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_cpuStrobe) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_memBusy) begin
                    cs_pulse = 1'b1;
                    state_d  = WAIT_ACCEPT;
                end else if (timer_expired) begin
                    abort   = 1'b1;
                    state_d = COMPLETE;
                end
            end
            WAIT_ACCEPT: begin
                if (i_memBusy) begin
                    state_d = WAIT_DONE;
                end else if (!o_memWrite && i_memDataReady) begin
                    // Controller answered without ever showing busy.
                    capture_read = 1'b1;
                    state_d      = COMPLETE;
                end else if (timer_expired) begin
                    abort   = 1'b1;
                    state_d = COMPLETE;
                end
            end
            WAIT_DONE: begin
                if (o_memWrite && !i_memBusy) begin
                    state_d = COMPLETE;
                end else if (!o_memWrite && i_memDataReady && !i_memBusy) begin
                    capture_read = 1'b1;
                    state_d      = COMPLETE;
                end else if (timer_expired) begin
                    abort   = 1'b1;
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields are captured once at the strobe and left untouched
    // afterwards, so they are stable through the chip-select clock and keep
    // their last values after completion.
    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            o_memWrite       <= 1'b0;
            o_memAddress     <= '0;
            o_memDataToWrite <= 8'h00;
        end else if (state_q == IDLE && i_cpuStrobe) begin
            o_memWrite       <= i_cpuWE;
            o_memAddress     <= map_cpu_addr(BASE_ADDR, i_cpuAddr);
            o_memDataToWrite <= i_cpuDataOut;
        end
    end

    // Registered so the low pulse lasts exactly one full clock.
    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            o_memCs <= 1'b1;
        end else begin
            o_memCs <= !cs_pulse;
        end
    end

    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            o_cpuDataIn <= 8'h00;
        end else if (capture_read) begin
            o_cpuDataIn <= i_memDataRead;
        end else if (abort && !o_memWrite) begin
            o_cpuDataIn <= BRIDGE_ABORT_DATA;
        end
    end

    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (abort) begin
                o_timeout <= 1'b1;
            end
            if (i_cpuStrobe && state_q != IDLE) begin
                o_overrun <= 1'b1;
            end
        end
    end

    // Decoded from the state register so reset releases the CPU immediately.
    assign o_cpuRdy  = (state_q == IDLE) || (state_q == COMPLETE);
    assign o_memBank = BANK;

endmodule
